// File: rtl/instr_realigner.sv
// Instruction realigner: turns 32-bit aligned fetch words into one instruction per
// decode handshake, splitting compressed halfwords and stitching straddling 32-bit ones.
module instr_realigner #(
    parameter int unsigned VLEN = 64
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            fetch_valid_i,
    output logic            fetch_ready_o,
    input  logic [VLEN-1:0] fetch_addr_i,
    input  logic [31:0]     fetch_data_i,
    input  logic            fetch_ex_i,
    output logic            instr_valid_o,
    input  logic            instr_ready_i,
    output logic [31:0]     instr_o,
    output logic [VLEN-1:0] instr_addr_o,
    output logic            instr_is_compressed_o,
    output logic            instr_ex_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PART = 2'd1,
        ST_COMP = 2'd2
    } state_e;

    localparam logic [VLEN-1:0] HALF_STEP = {{(VLEN-2){1'b0}}, 2'b10};

    function automatic logic is_compressed(input logic [15:0] hw);
        return (hw[1:0] != 2'b11);
    endfunction

    state_e          state_q, state_d;
    logic [15:0]     hw_q, hw_d;
    logic [VLEN-1:0] ha_q, ha_d;

    logic [15:0]     lo_hw_s;
    logic [15:0]     up_hw_s;
    logic [VLEN-1:0] up_addr_s;
    logic [VLEN-1:0] next_addr_s;

    assign lo_hw_s     = fetch_data_i[15:0];
    assign up_hw_s     = fetch_data_i[31:16];
    assign up_addr_s   = fetch_addr_i | HALF_STEP;
    assign next_addr_s = fetch_addr_i + HALF_STEP;

    // Next-state and zero-latency output decode from the held halfword and current fetch word.
    always_comb begin
        state_d               = state_q;
        hw_d                  = hw_q;
        ha_d                  = ha_q;
        fetch_ready_o         = 1'b0;
        instr_valid_o         = 1'b0;
        instr_o               = 32'd0;
        instr_addr_o          = {VLEN{1'b0}};
        instr_is_compressed_o = 1'b0;
        instr_ex_o            = 1'b0;

        if (flush_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_COMP: begin
                    // The held compressed instruction always drains before any new word.
                    instr_valid_o         = 1'b1;
                    instr_o               = {16'd0, hw_q};
                    instr_addr_o          = ha_q;
                    instr_is_compressed_o = 1'b1;
                    if (instr_ready_i) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_COMP;
                    end
                end
                ST_PART: begin
                    if (fetch_valid_i) begin
                        instr_valid_o = 1'b1;
                        instr_addr_o  = ha_q;
                        if (fetch_ex_i) begin
                            instr_o    = fetch_data_i;
                            instr_ex_o = 1'b1;
                            if (instr_ready_i) begin
                                fetch_ready_o = 1'b1;
                                state_d       = ST_IDLE;
                            end else begin
                                state_d = ST_PART;
                            end
                        end else begin
                            instr_o = {lo_hw_s, hw_q};
                            if (instr_ready_i) begin
                                fetch_ready_o = 1'b1;
                                hw_d          = up_hw_s;
                                ha_d          = next_addr_s;
                                state_d       = is_compressed(up_hw_s) ? ST_COMP : ST_PART;
                            end else begin
                                state_d = ST_PART;
                            end
                        end
                    end else begin
                        state_d = ST_PART;
                    end
                end
                ST_IDLE: begin
                    if (fetch_valid_i) begin
                        if (fetch_ex_i) begin
                            instr_valid_o = 1'b1;
                            instr_o       = fetch_data_i;
                            instr_addr_o  = fetch_addr_i;
                            instr_ex_o    = 1'b1;
                            if (instr_ready_i) begin
                                fetch_ready_o = 1'b1;
                            end else begin
                                fetch_ready_o = 1'b0;
                            end
                        end else if (fetch_addr_i[1]) begin
                            if (is_compressed(up_hw_s)) begin
                                instr_valid_o         = 1'b1;
                                instr_o               = {16'd0, up_hw_s};
                                instr_addr_o          = up_addr_s;
                                instr_is_compressed_o = 1'b1;
                                if (instr_ready_i) begin
                                    fetch_ready_o = 1'b1;
                                end else begin
                                    fetch_ready_o = 1'b0;
                                end
                            end else if (instr_ready_i) begin
                                // Load-only: still frozen by a stalled decode so nothing moves.
                                fetch_ready_o = 1'b1;
                                hw_d          = up_hw_s;
                                ha_d          = up_addr_s;
                                state_d       = ST_PART;
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end else if (!is_compressed(lo_hw_s)) begin
                            instr_valid_o = 1'b1;
                            instr_o       = fetch_data_i;
                            instr_addr_o  = fetch_addr_i;
                            if (instr_ready_i) begin
                                fetch_ready_o = 1'b1;
                            end else begin
                                fetch_ready_o = 1'b0;
                            end
                        end else begin
                            instr_valid_o         = 1'b1;
                            instr_o               = {16'd0, lo_hw_s};
                            instr_addr_o          = fetch_addr_i;
                            instr_is_compressed_o = 1'b1;
                            if (instr_ready_i) begin
                                fetch_ready_o = 1'b1;
                                hw_d          = up_hw_s;
                                ha_d          = next_addr_s;
                                state_d       = is_compressed(up_hw_s) ? ST_COMP : ST_PART;
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and halfword holding register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            hw_q    <= 16'd0;
            ha_q    <= {VLEN{1'b0}};
        end else begin
            state_q <= state_d;
            hw_q    <= hw_d;
            ha_q    <= ha_d;
        end
    end

endmodule

// File: tb/tb_instr_realigner.sv
// Bench for instr_realigner: directed cycle-level checks, then randomized words against a
// halfword-stream reference model with a queue-based scoreboard.
module tb_instr_realigner;

    localparam int VLEN = 64;

    typedef struct packed {
        logic [31:0]     instr;
        logic [VLEN-1:0] addr;
        logic            comp;
        logic            ex;
    } entry_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            flush;
    logic            fetch_valid;
    logic            fetch_ready;
    logic [VLEN-1:0] fetch_addr;
    logic [31:0]     fetch_data;
    logic            fetch_ex;
    logic            instr_valid;
    logic            instr_ready;
    logic [31:0]     instr;
    logic [VLEN-1:0] instr_addr;
    logic            instr_comp;
    logic            instr_ex;

    int     tests = 0;
    int     fails = 0;
    entry_t exp_q[$];
    bit     mon_en = 1'b0;
    bit     rand_rdy = 1'b0;
    logic   man_rdy = 1'b1;
    logic   rnd_rdy = 1'b1;

    // reference model: at most one leftover halfword between fetch words
    bit              left_v = 1'b0;
    logic [15:0]     left_hw;
    logic [VLEN-1:0] left_a;

    always #5 clk = ~clk;
    assign instr_ready = rand_rdy ? rnd_rdy : man_rdy;

    instr_realigner #(.VLEN(VLEN)) dut (
        .clk_i                 (clk),
        .rst_ni                (rst_n),
        .flush_i               (flush),
        .fetch_valid_i         (fetch_valid),
        .fetch_ready_o         (fetch_ready),
        .fetch_addr_i          (fetch_addr),
        .fetch_data_i          (fetch_data),
        .fetch_ex_i            (fetch_ex),
        .instr_valid_o         (instr_valid),
        .instr_ready_i         (instr_ready),
        .instr_o               (instr),
        .instr_addr_o          (instr_addr),
        .instr_is_compressed_o (instr_comp),
        .instr_ex_o            (instr_ex)
    );

    function automatic bit is_c(input logic [15:0] h);
        return h[1:0] != 2'b11;
    endfunction

    // Split the word into halfwords, append to the leftover and parse instructions greedily.
    task automatic model_word(input logic [VLEN-1:0] a, input logic [31:0] d, input bit ex);
        logic [15:0]     hq[$];
        logic [VLEN-1:0] aq[$];
        entry_t          e;
        if (ex) begin
            e = '{d, (left_v ? left_a : a), 1'b0, 1'b1};
            exp_q.push_back(e);
            left_v = 1'b0;
            return;
        end
        if (left_v) begin
            hq.push_back(left_hw);
            aq.push_back(left_a);
        end
        left_v = 1'b0;
        if (!a[1]) begin
            hq.push_back(d[15:0]);
            aq.push_back(a);
            hq.push_back(d[31:16]);
            aq.push_back(a + 64'd2);
        end else begin
            hq.push_back(d[31:16]);
            aq.push_back(a);
        end
        while (hq.size() > 0) begin
            if (is_c(hq[0])) begin
                e = '{{16'h0000, hq[0]}, aq[0], 1'b1, 1'b0};
                exp_q.push_back(e);
                void'(hq.pop_front());
                void'(aq.pop_front());
            end else if (hq.size() >= 2) begin
                e = '{{hq[1], hq[0]}, aq[0], 1'b0, 1'b0};
                exp_q.push_back(e);
                void'(hq.pop_front());
                void'(hq.pop_front());
                void'(aq.pop_front());
                void'(aq.pop_front());
            end else begin
                left_v  = 1'b1;
                left_hw = hq.pop_front();
                left_a  = aq.pop_front();
            end
        end
    endtask

    task automatic put(input bit v, input logic [VLEN-1:0] a, input logic [31:0] d, input bit ex);
        fetch_valid = v;
        fetch_addr  = a;
        fetch_data  = d;
        fetch_ex    = ex;
    endtask

    task automatic expect_out(input string name, input bit v, input logic [31:0] i,
                              input logic [VLEN-1:0] a, input bit c, input bit ex, input bit fr);
        tests++;
        if (instr_valid !== v || fetch_ready !== fr ||
            (v && ({instr, instr_addr, instr_comp, instr_ex} !== {i, a, c, ex}))) begin
            fails++;
            $display("FAIL %s: got v=%b fr=%b instr=%h addr=%h c=%b ex=%b, want v=%b fr=%b instr=%h addr=%h c=%b ex=%b",
                     name, instr_valid, fetch_ready, instr, instr_addr, instr_comp, instr_ex,
                     v, fr, i, a, c, ex);
        end
    endtask

    function automatic logic [15:0] rand_hw(input bit comp);
        logic [15:0] h;
        h = 16'($urandom);
        if (!comp) h[1:0] = 2'b11;
        else if (h[1:0] == 2'b11) h[1:0] = 2'b01;
        return h;
    endfunction

    // Scoreboard monitor: pops one expectation per observed handshake.
    entry_t prev_e;
    bit     prev_stall = 1'b0;
    always @(negedge clk) begin
        entry_t cur;
        entry_t want;
        #2;
        cur = '{instr, instr_addr, instr_comp, instr_ex};
        if (mon_en) begin
            if (prev_stall) begin
                tests++;
                if (instr_valid !== 1'b1 || cur !== prev_e) begin
                    fails++;
                    $display("FAIL stall_stable: got v=%b %h, want v=1 %h", instr_valid, cur, prev_e);
                end
            end
            if (instr_valid && instr_ready) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_entry: got %h, want none", cur);
                end else begin
                    want = exp_q.pop_front();
                    if (cur !== want) begin
                        fails++;
                        $display("FAIL entry: got instr=%h addr=%h c=%b ex=%b, want instr=%h addr=%h c=%b ex=%b",
                                 cur.instr, cur.addr, cur.comp, cur.ex,
                                 want.instr, want.addr, want.comp, want.ex);
                    end
                end
            end
            prev_stall = instr_valid && !instr_ready;
            prev_e     = cur;
        end else begin
            prev_stall = 1'b0;
        end
    end

    always @(negedge clk) rnd_rdy = ($urandom_range(0, 3) != 0);

    // Present a word until consumed; called just after a falling edge.
    task automatic send_word(input logic [VLEN-1:0] a, input logic [31:0] d, input bit ex);
        put(1'b1, a, d, ex);
        for (int n = 0; ; n++) begin
            #1;
            if (fetch_ready === 1'b1) break;
            if (n >= 200) begin
                tests++;
                fails++;
                $display("FAIL consume_timeout: got no fetch_ready, want consume of %h", a);
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        fetch_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            #3;
            n++;
        end
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL %s: got %0d pending entries, want 0", name, exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        logic [VLEN-1:0] cur_a;
        logic [31:0]     d;
        bit              ex;
        rst_n = 1'b0;
        flush = 1'b0;
        put(1'b0, '0, 32'd0, 1'b0);
        #12;
        expect_out("reset_state", 1'b0, 32'd0, '0, 1'b0, 1'b0, 1'b0);
        @(negedge clk); rst_n = 1'b1;

        @(negedge clk); put(1'b1, 64'h1000, 32'h00A00093, 1'b0); #1;
        expect_out("plain32", 1'b1, 32'h00A00093, 64'h1000, 1'b0, 1'b0, 1'b1);
        @(negedge clk); put(1'b1, 64'h2000, 32'h40014501, 1'b0); #1;
        expect_out("two_c_lo", 1'b1, 32'h4501, 64'h2000, 1'b1, 1'b0, 1'b1);
        @(negedge clk); put(1'b0, '0, 32'd0, 1'b0); man_rdy = 1'b0; #1;
        expect_out("two_c_hi", 1'b1, 32'h4001, 64'h2002, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 2) put(1'b1, 64'h3000, 32'h00934505, 1'b0);
            #1;
            expect_out("backpressure", 1'b1, 32'h4001, 64'h2002, 1'b1, 1'b0, 1'b0);
        end
        @(negedge clk); man_rdy = 1'b1; #1;
        expect_out("bp_release", 1'b1, 32'h4001, 64'h2002, 1'b1, 1'b0, 1'b0);
        @(negedge clk); #1;
        expect_out("straddle_lo", 1'b1, 32'h4505, 64'h3000, 1'b1, 1'b0, 1'b1);
        @(negedge clk); put(1'b1, 64'h3004, 32'h12340093, 1'b0); #1;
        expect_out("straddle_join", 1'b1, 32'h00930093, 64'h3002, 1'b0, 1'b0, 1'b1);
        @(negedge clk); put(1'b0, '0, 32'd0, 1'b0); #1;
        expect_out("straddle_tail", 1'b1, 32'h1234, 64'h3006, 1'b1, 1'b0, 1'b0);
        @(negedge clk); put(1'b1, 64'h4002, 32'h05130000, 1'b0); #1;
        expect_out("redirect_load", 1'b0, 32'd0, '0, 1'b0, 1'b0, 1'b1);
        @(negedge clk); put(1'b1, 64'h4004, 32'h00000000, 1'b0); #1;
        expect_out("redirect_join", 1'b1, 32'h00000513, 64'h4002, 1'b0, 1'b0, 1'b1);
        @(negedge clk); put(1'b0, '0, 32'd0, 1'b0); #1;
        expect_out("redirect_tail", 1'b1, 32'h0, 64'h4006, 1'b1, 1'b0, 1'b0);
        @(negedge clk); put(1'b1, 64'h4002, 32'h05130000, 1'b0); #1;
        expect_out("flush_prep", 1'b0, 32'd0, '0, 1'b0, 1'b0, 1'b1);
        @(negedge clk); put(1'b1, 64'h5000, 32'h00A00093, 1'b0); flush = 1'b1; #1;
        expect_out("flush_cycle", 1'b0, 32'd0, '0, 1'b0, 1'b0, 1'b0);
        @(negedge clk); flush = 1'b0; #1;
        expect_out("after_flush", 1'b1, 32'h00A00093, 64'h5000, 1'b0, 1'b0, 1'b1);
        @(negedge clk); put(1'b1, 64'h6000, 32'h00934501, 1'b0); #1;
        expect_out("fault_prep", 1'b1, 32'h4501, 64'h6000, 1'b1, 1'b0, 1'b1);
        @(negedge clk); put(1'b1, 64'h6004, 32'hDEADBEEF, 1'b1); #1;
        expect_out("fault_part", 1'b1, 32'hDEADBEEF, 64'h6002, 1'b0, 1'b1, 1'b1);
        @(negedge clk); put(1'b1, 64'h7000, 32'h00A00093, 1'b0); #1;
        expect_out("after_fault", 1'b1, 32'h00A00093, 64'h7000, 1'b0, 1'b0, 1'b1);
        @(negedge clk); put(1'b1, 64'h7004, 32'h40014501, 1'b0); #1;
        expect_out("cfault_lo", 1'b1, 32'h4501, 64'h7004, 1'b1, 1'b0, 1'b1);
        @(negedge clk); put(1'b1, 64'h7008, 32'hCAFEF00D, 1'b1); #1;
        expect_out("cfault_held", 1'b1, 32'h4001, 64'h7006, 1'b1, 1'b0, 1'b0);
        @(negedge clk); #1;
        expect_out("cfault_entry", 1'b1, 32'hCAFEF00D, 64'h7008, 1'b0, 1'b1, 1'b1);
        @(negedge clk); put(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 32'h00934501, 1'b0); #1;
        expect_out("wrap_lo", 1'b1, 32'h4501, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 1'b0, 1'b1);
        @(negedge clk); put(1'b1, 64'h0, 32'h00000000, 1'b0); #1;
        expect_out("wrap_join", 1'b1, 32'h00000093, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b1);
        @(negedge clk); put(1'b0, '0, 32'd0, 1'b0); #1;
        expect_out("wrap_tail", 1'b1, 32'h0, 64'h2, 1'b1, 1'b0, 1'b0);
        @(negedge clk); put(1'b1, 64'h8000, 32'h40014501, 1'b0); #1;
        expect_out("areset_lo", 1'b1, 32'h4501, 64'h8000, 1'b1, 1'b0, 1'b1);
        @(negedge clk); put(1'b0, '0, 32'd0, 1'b0); man_rdy = 1'b0; #1;
        expect_out("areset_hold", 1'b1, 32'h4001, 64'h8002, 1'b1, 1'b0, 1'b0);
        #2; rst_n = 1'b0; #1;
        expect_out("areset_now", 1'b0, 32'd0, '0, 1'b0, 1'b0, 1'b0);
        @(negedge clk); rst_n = 1'b1; man_rdy = 1'b1; #1;
        expect_out("areset_idle", 1'b0, 32'd0, '0, 1'b0, 1'b0, 1'b0);

        // randomized phase
        @(negedge clk);
        mon_en   = 1'b1;
        rand_rdy = 1'b1;
        left_v   = 1'b0;
        cur_a    = 64'h0001_0000;
        for (int w = 0; w < 400; w++) begin
            if ($urandom_range(0, 9) == 0) begin
                wait_drain("pre_flush_drain");
                flush = 1'b1;
                #1;
                tests++;
                if (instr_valid !== 1'b0 || fetch_ready !== 1'b0) begin
                    fails++;
                    $display("FAIL rand_flush: got v=%b fr=%b, want 0 0", instr_valid, fetch_ready);
                end
                @(negedge clk);
                flush  = 1'b0;
                left_v = 1'b0;
                if ($urandom_range(0, 3) == 0) cur_a = 64'hFFFF_FFFF_FFFF_FFF0;
                else cur_a = {32'($urandom), 32'($urandom)};
                cur_a[0] = 1'b0;
            end
            d  = {rand_hw($urandom_range(0, 1) == 1), rand_hw($urandom_range(0, 1) == 1)};
            ex = ($urandom_range(0, 11) == 0);
            model_word(cur_a, d, ex);
            send_word(cur_a, d, ex);
            cur_a = (cur_a & ~64'd3) + 64'd4;
        end
        wait_drain("final_drain");
        mon_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
